hold_field: RTL
===============

HOLD_FIELD -- requirements
Module: hold_field

Interface
REQ-001 Parameter WIDTH, default 64, hold width in world pixels.
REQ-002 Parameter HEIGHT, default 24, hold height in world pixels.
REQ-003 Parameter NUM_HOLDS, default 8, number of hold table entries (2..64).
REQ-004 Parameter IDX_W, default 3, index width; SHALL equal clog2(NUM_HOLDS).
REQ-005 clock  in  1  sole clock; all logic on rising edge.
REQ-006 reset_n  in  1  synchronous, active-low reset.
REQ-007 hcount  in  11  screen pixel column.
REQ-008 vcount  in  10  screen pixel row.
REQ-009 screenx  in  12 signed  world x of screen column 0.
REQ-010 screeny  in  13 signed  world y of screen row 0.
REQ-011 wr_en  in  1  write one table entry this cycle.
REQ-012 wr_idx  in  IDX_W  entry written.
REQ-013 wr_x / wr_y  in  12 / 13 signed  entry top-left world corner.
REQ-014 wr_valid  in  1  entry enable bit written alongside position.
REQ-015 exists  out  1  registered: pixel lies inside an enabled hold.
REQ-016 hold_idx  out  IDX_W  registered: index of that hold; 0 when exists=0.
REQ-017 q_req  in  1  single-cycle grab-query request.
REQ-018 q_x / q_y  in  12 / 13 signed  world point queried.
REQ-019 q_busy  out  1  query scan in progress.
REQ-020 q_done  out  1  one-cycle pulse, query result valid.
REQ-021 q_hit / q_idx  out  1 / IDX_W  query result, held until next accepted request.

Function
REQ-022 Table write SHALL take effect at the clock edge with wr_en=1; out-of-range wr_idx is ignored.
REQ-023 World coordinates wx=hcount+screenx, wy=vcount+screeny SHALL be computed sign-extended to 13/14 bits; bounds x+WIDTH, y+HEIGHT computed without overflow.
REQ-024 Hit for entry i: valid_i and x_i<=wx<x_i+WIDTH and y_i<=wy<y_i+HEIGHT, all signed compares (half-open box).
REQ-025 Pixel path SHALL be a 2-stage pipeline: stage 1 registers wx/wy; stage 2 registers exists/hold_idx; latency exactly 2 cycles from hcount/vcount, throughput 1 pixel/cycle.
REQ-026 Overlapping hits: lowest index wins.
REQ-027 Write coinciding with a stage-2 compare: compare uses pre-write contents.
REQ-028 Query FSM states IDLE, SCAN, DONE.
REQ-029 IDLE: q_req=1 latches q_x/q_y, clears scan counter, goes SCAN; q_busy=1 from next cycle.
REQ-030 SCAN: tests one entry per cycle, index 0 upward, using REQ-024 rule against latched point; on first hit records q_hit=1,q_idx=i, goes DONE; after entry NUM_HOLDS-1 with no hit records q_hit=0,q_idx=0, goes DONE.
REQ-031 DONE: q_done=1 and q_busy=0 for exactly one cycle, then IDLE.
REQ-032 q_req while SCAN or DONE SHALL be ignored (not queued).
REQ-033 Table writes during SCAN are visible to entries not yet tested.
REQ-034 Worst-case query latency: q_req to q_done = NUM_HOLDS+1 cycles.

Reset
REQ-035 reset_n=0 at an edge SHALL clear all valid bits, exists=0, hold_idx=0, pipeline registers=0, FSM=IDLE, q_busy=q_done=q_hit=0, q_idx=0.
REQ-036 Reset mid-scan SHALL abort the scan with no q_done pulse.
REQ-037 Entry positions need not be reset; only valid bits.

Configuration
REQ-038 Macro HOLD_FIELD_GRAB_EN defined: query port and FSM per REQ-028..034 present.
REQ-039 Macro undefined: query FSM omitted; q_busy, q_done, q_hit, q_idx tied 0; q_req, q_x, q_y ignored; pixel path unchanged.

Verification
REQ-040 Entry 2 = (100,50,valid); screen (0,0); hcount 99/100/163/164 at vcount 50 -> exists 0/1/1/0 two cycles later, hold_idx=2 when 1.
REQ-041 Entries 1 and 5 both at (10,10); pixel (20,20) -> exists=1, hold_idx=1; disable entry 1 -> hold_idx=5.
REQ-042 screenx=-40, screeny=-2000, entry 0 = (-30,-1990); pixel hcount=15, vcount=12 -> exists=1; hcount=5 -> exists=0.
REQ-043 GRAB_EN, only entry 6 hit by q=(300,200) -> q_done exactly 8 cycles after q_req, q_hit=1, q_idx=6; second q_req during SCAN ignored.
REQ-044 GRAB_EN, empty table, q_req -> q_done after NUM_HOLDS+1=9 cycles, q_hit=0; reset_n=0 on cycle 4 -> q_busy=0, no q_done.
REQ-045 Reset with entries loaded -> exists=0 for every pixel until rewritten.

Source files
------------

// File: rtl/hold_field_if.sv
// Hold-field bus: pixel lookup, hold table writes and grab-query handshake.
interface hold_field_if #(
    parameter int IDX_W = 3
);
    logic        [10:0]      hcount;
    logic        [9:0]       vcount;
    logic signed [11:0]      screenx;
    logic signed [12:0]      screeny;
    logic                    wr_en;
    logic        [IDX_W-1:0] wr_idx;
    logic signed [11:0]      wr_x;
    logic signed [12:0]      wr_y;
    logic                    wr_valid;
    logic                    exists;
    logic        [IDX_W-1:0] hold_idx;
    logic                    q_req;
    logic signed [11:0]      q_x;
    logic signed [12:0]      q_y;
    logic                    q_busy;
    logic                    q_done;
    logic                    q_hit;
    logic        [IDX_W-1:0] q_idx;

    modport master (
        output hcount, vcount, screenx, screeny,
        output wr_en, wr_idx, wr_x, wr_y, wr_valid,
        output q_req, q_x, q_y,
        input  exists, hold_idx,
        input  q_busy, q_done, q_hit, q_idx
    );

    modport slave (
        input  hcount, vcount, screenx, screeny,
        input  wr_en, wr_idx, wr_x, wr_y, wr_valid,
        input  q_req, q_x, q_y,
        output exists, hold_idx,
        output q_busy, q_done, q_hit, q_idx
    );
endinterface

// File: rtl/hold_field.sv
// Hold table with 2-stage pixel hit pipeline; optional grab-query scanner
// enabled by defining HOLD_FIELD_GRAB_EN.
module hold_field #(
    parameter int WIDTH     = 64,
    parameter int HEIGHT    = 24,
    parameter int NUM_HOLDS = 8,
    parameter int IDX_W     = 3
) (
    input logic        clock,
    input logic        reset_n,
    hold_field_if.slave bus
);
    typedef logic signed [15:0] s16_t;

    logic signed [11:0]    tx [NUM_HOLDS];
    logic signed [12:0]    ty [NUM_HOLDS];
    logic [NUM_HOLDS-1:0]  tv;

    logic signed [12:0] wx_n, wx;
    logic signed [13:0] wy_n, wy;
    logic               pe;
    logic [IDX_W-1:0]   pi;

    // Half-open box test, widened to 16 bits so x+WIDTH cannot wrap.
    function automatic logic inb(
        input logic signed [11:0] x,
        input logic signed [12:0] y,
        input s16_t px,
        input s16_t py
    );
        s16_t x0, y0;
        x0 = 16'(x);
        y0 = 16'(y);
        return (px >= x0) && (px < x0 + 16'(WIDTH)) &&
               (py >= y0) && (py < y0 + 16'(HEIGHT));
    endfunction

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tv <= '0;
        end else if (bus.wr_en && int'(bus.wr_idx) < NUM_HOLDS) begin
            tv[bus.wr_idx] <= bus.wr_valid;
        end
    end

    always_ff @(posedge clock) begin
        if (bus.wr_en && int'(bus.wr_idx) < NUM_HOLDS) begin
            tx[bus.wr_idx] <= bus.wr_x;
            ty[bus.wr_idx] <= bus.wr_y;
        end
    end

    assign wx_n = $signed({2'b00, bus.hcount}) + 13'(bus.screenx);
    assign wy_n = $signed({4'b0000, bus.vcount}) + 14'(bus.screeny);

    // Descending scan so the lowest matching index is the one kept.
    always_comb begin
        pe = 1'b0;
        pi = '0;
        for (int i = NUM_HOLDS - 1; i >= 0; i--) begin
            if (tv[i] && inb(tx[i], ty[i], 16'(wx), 16'(wy))) begin
                pe = 1'b1;
                pi = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wx           <= '0;
            wy           <= '0;
            bus.exists   <= 1'b0;
            bus.hold_idx <= '0;
        end else begin
            wx           <= wx_n;
            wy           <= wy_n;
            bus.exists   <= pe;
            bus.hold_idx <= pi;
        end
    end

`ifdef HOLD_FIELD_GRAB_EN
    typedef enum logic [1:0] {IDLE, SCAN, DONE} qstate_t;

    qstate_t            qs;
    logic [IDX_W-1:0]   qcnt;
    logic signed [11:0] qx;
    logic signed [12:0] qy;
    logic               qmatch;

    assign qmatch = tv[qcnt] && inb(tx[qcnt], ty[qcnt], 16'(qx), 16'(qy));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            qs         <= IDLE;
            qcnt       <= '0;
            qx         <= '0;
            qy         <= '0;
            bus.q_busy <= 1'b0;
            bus.q_done <= 1'b0;
            bus.q_hit  <= 1'b0;
            bus.q_idx  <= '0;
        end else begin
            unique case (qs)
                IDLE: begin
                    if (bus.q_req) begin
                        qx         <= bus.q_x;
                        qy         <= bus.q_y;
                        qcnt       <= '0;
                        bus.q_busy <= 1'b1;
                        bus.q_hit  <= 1'b0;
                        bus.q_idx  <= '0;
                        qs         <= SCAN;
                    end
                end
                SCAN: begin
                    if (qmatch) begin
                        bus.q_hit  <= 1'b1;
                        bus.q_idx  <= qcnt;
                        bus.q_busy <= 1'b0;
                        bus.q_done <= 1'b1;
                        qs         <= DONE;
                    end else if (qcnt == IDX_W'(NUM_HOLDS - 1)) begin
                        bus.q_hit  <= 1'b0;
                        bus.q_idx  <= '0;
                        bus.q_busy <= 1'b0;
                        bus.q_done <= 1'b1;
                        qs         <= DONE;
                    end else begin
                        qcnt <= qcnt + IDX_W'(1);
                    end
                end
                DONE: begin
                    bus.q_done <= 1'b0;
                    qs         <= IDLE;
                end
                default: qs <= IDLE;
            endcase
        end
    end
`else
    logic unused_q;

    assign unused_q   = ^{bus.q_req, bus.q_x, bus.q_y};
    assign bus.q_busy = 1'b0;
    assign bus.q_done = 1'b0;
    assign bus.q_hit  = 1'b0;
    assign bus.q_idx  = '0;
`endif
endmodule
